// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and parity-mode codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop synchroniser for the serial line plus 3-sample majority vote.
// Samples are taken at bit-relative counts MID-1 and MID; the vote output
// combines them with the live synchronised level and is meaningful at MID+1.
module uart_bit_sampler #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_async,
  input  logic [CNT_W-1:0] bit_cnt,
  output logic             rx_sync,
  output logic             vote
);

  localparam int unsigned      MID        = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic s0_q, s0_d;
  logic s1_q, s1_d;

  // Next-state for synchroniser chain and the two early vote samples
  always_comb begin
    meta_d = rx_async;
    sync_d = meta_q;
    s0_d   = s0_q;
    s1_d   = s1_q;
    if (bit_cnt == CNT_MID_M1) s0_d = sync_q;
    if (bit_cnt == CNT_MID)    s1_d = sync_q;
  end

  // Synchroniser idles high so reset never looks like a start bit edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
    end
  end

  assign rx_sync = sync_q;
  assign vote    = (s0_q & s1_q) | (s0_q & sync_q) | (s1_q & sync_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with valid/ready output and overrun detection.
// Optional parity checking is compiled in with macro UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Rx_Serial,
  input  logic [1:0]           i_Parity_Mode,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_DV,
  input  logic                 i_Rx_Ready,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned      IDX_W     = $clog2(DATA_BITS + 1);
  localparam int unsigned      MID       = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  rx_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 nonzero_q, nonzero_d;
  logic                 stop0_zero_q, stop0_zero_d;
  logic                 fe_acc_q, fe_acc_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 rx_dv_q, rx_dv_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_q, break_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_sync, vote, at_vote, at_end;
  logic                 frame_done, done_fe, done_brk;

  uart_bit_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_sampler (
    .clk     (i_Clock),
    .rst_n   (i_Reset_n),
    .rx_async(i_Rx_Serial),
    .bit_cnt (cnt_q),
    .rx_sync (rx_sync),
    .vote    (vote)
  );

  assign at_vote = (cnt_q == CNT_VOTE);
  assign at_end  = (cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic [1:0] pmode_q, pmode_d;
  logic       pe_acc_q, pe_acc_d;
  logic       parity_err_q, parity_err_d;
  logic       par_en, par_expect;
  assign par_en     = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign par_expect = (pmode_q == PAR_ODD) ? ~(^shift_q) : ^shift_q;
`else
  logic unused_par_mode;
  assign unused_par_mode = ^i_Parity_Mode;
`endif

  // Frame FSM: bit timing, data shifting and per-frame error accumulation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    shift_d      = shift_q;
    nonzero_d    = nonzero_q;
    stop0_zero_d = stop0_zero_q;
    fe_acc_d     = fe_acc_q;
    frame_done   = 1'b0;
    done_fe      = 1'b0;
    done_brk     = 1'b0;
`ifdef UART_RX_PARITY_EN
    pmode_d  = pmode_q;
    pe_acc_d = pe_acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_sync) begin
          state_d      = ST_START;
          nonzero_d    = 1'b0;
          stop0_zero_d = 1'b0;
          fe_acc_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
          pmode_d  = i_Parity_Mode;
          pe_acc_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (vote) nonzero_d = 1'b1;
        end
        if (at_end) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = par_en ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (at_vote) begin
          pe_acc_d = vote ^ par_expect;
          if (vote) nonzero_d = 1'b1;
        end
        if (at_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (at_vote) begin
          if (!vote) fe_acc_d = 1'b1;
          if (idx_q == '0) stop0_zero_d = !vote;
          // Finish at the last vote rather than bit end so a following start
          // edge is seen in IDLE with the full half-bit of margin.
          if (idx_q == STOP_LAST) begin
            frame_done = 1'b1;
            done_fe    = fe_acc_q | !vote;
            done_brk   = !nonzero_q && ((idx_q == '0) ? !vote : stop0_zero_q);
            state_d    = ST_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
          end
        end else if (at_end) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output holding register: load on completion if free, else flag overrun
  always_comb begin
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = rx_dv_q;
    frame_err_d = frame_err_q;
    break_d     = break_q;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (frame_done && (!rx_dv_q || i_Rx_Ready)) begin
      rx_byte_d   = shift_q;
      rx_dv_d     = 1'b1;
      frame_err_d = done_fe;
      break_d     = done_brk;
`ifdef UART_RX_PARITY_EN
      parity_err_d = pe_acc_q;
`endif
    end else begin
      if (frame_done) overrun_d = 1'b1;
      if (rx_dv_q && i_Rx_Ready) rx_dv_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      nonzero_q    <= 1'b0;
      stop0_zero_q <= 1'b0;
      fe_acc_q     <= 1'b0;
      rx_byte_q    <= '0;
      rx_dv_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pmode_q      <= PAR_NONE;
      pe_acc_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      nonzero_q    <= nonzero_d;
      stop0_zero_q <= stop0_zero_d;
      fe_acc_q     <= fe_acc_d;
      rx_byte_q    <= rx_byte_d;
      rx_dv_q      <= rx_dv_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      pmode_q      <= pmode_d;
      pe_acc_q     <= pe_acc_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign o_Rx_Byte   = rx_byte_q;
  assign o_Rx_DV     = rx_dv_q;
  assign o_Frame_Err = frame_err_q;
  assign o_Break     = break_q;
  assign o_Overrun   = overrun_q;
  assign o_Busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = parity_err_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (CLKS_PER_BIT=16, 8N1 framing).
// Parity expectations follow UART_RX_PARITY_EN when the bench is built.
module tb_uart_rx_param;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] par_mode = 2'b00;
  logic       ready = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_dv, frame_err, parity_err, brk, overrun, busy;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ovr_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1)
  ) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Rx_Serial  (rx),
    .i_Parity_Mode(par_mode),
    .o_Rx_Byte    (rx_byte),
    .o_Rx_DV      (rx_dv),
    .i_Rx_Ready   (ready),
    .o_Frame_Err  (frame_err),
    .o_Parity_Err (parity_err),
    .o_Break      (brk),
    .o_Overrun    (overrun),
    .o_Busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n && overrun) ovr_cnt++;
    if (rst_n && rx_dv && ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dv", {24'd0, rx_byte}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_byte", {24'd0, rx_byte}, {24'd0, e.data});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        chk("break", {31'd0, brk}, {31'd0, e.brk});
      end
    end
  end

  // One bit time on the line; optional single-clock inverted spike mid-bit
  task automatic drive_bit(input logic b, input bit spike);
    for (int i = 0; i < int'(CPB); i++) begin
      @(negedge clk);
      rx = (spike && i == 8) ? ~b : b;
    end
  endtask

  task automatic idle_bits(input int unsigned n);
    for (int i = 0; i < int'(n * CPB); i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Send one frame and record what a receiver should report for it
  task automatic send_frame(input logic [7:0] data, input logic [1:0] pmode, input bit pflip,
                            input logic stop, input bit expect_out, input logic [7:0] spike,
                            input int unsigned gap);
    bit   par_sent;
    logic pbit;
    exp_t e;
    par_sent = PAR_BUILD && (pmode == 2'b01 || pmode == 2'b10);
    pbit     = ((pmode == 2'b10) ? ~(^data) : ^data) ^ pflip;
    e.data   = data;
    e.ferr   = !stop;
    e.perr   = par_sent && pflip;
    e.brk    = (data == 8'h00) && (!par_sent || !pbit) && !stop;
    if (expect_out) exp_q.push_back(e);
    par_mode = pmode;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i], spike[i]);
    if (par_sent) drive_bit(pbit, 1'b0);
    drive_bit(stop, 1'b0);
    idle_bits(gap);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte"}, {24'd0, rx_byte}, 32'd0);
    chk({tag, "_dv"}, {31'd0, rx_dv}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
    chk({tag, "_brk"}, {31'd0, brk}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr_base;
    logic [7:0] d;
    logic s;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle_bits(2);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Directed frames
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 8'h00, 2);
    send_frame(8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, 8'h00, 2);
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 2);
    send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 2);
    send_frame(8'h96, 2'b00, 1'b0, 1'b1, 1'b1, 8'hFF, 2);

    // Short low glitch must not start a frame
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle_bits(3);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_dv", {31'd0, rx_dv}, 32'd0);

    // Overrun: consumer stalled across two frames
    @(posedge clk); #1 ready = 1'b0;
    ovr_base = ovr_cnt;
    send_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b1, 8'h00, 1);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1);
    @(negedge clk);
    chk("ovr_hold_dv", {31'd0, rx_dv}, 32'd1);
    chk("ovr_hold_byte", {24'd0, rx_byte}, 32'h11);
    chk("ovr_pulses", ovr_cnt - ovr_base, 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    idle_bits(1);
    chk("ovr_drained", exp_q.size(), 32'd0);

    // Randomised frames, including back-to-back and spiked bits
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), s, 1'b1,
                 8'($urandom), s ? $urandom_range(0, 2) : 2);
    end

    // Reset during data bit 4 aborts the frame; line held low restarts
    par_mode = 2'b00;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    send_frame(8'h7E, 2'b00, 1'b0, 1'b1, 1'b1, 8'h00, 2);

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
